// File: rtl/rv32_pkg.sv
// Shared RV32 register-file definitions: default geometry and the bulk-clear
// engine state type.
package rv32_pkg;

  localparam int XLEN    = 32;
  localparam int REG_NUM = 32;
  localparam int REG_AW  = $clog2(REG_NUM);

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits for decode hazard detection; entry 0 never goes busy.
// A new producer (set) outranks a retiring one (clear) on the same register.
module rf_scoreboard
  import rv32_pkg::*;
#(
  parameter int  REG_NUM = rv32_pkg::REG_NUM,
  localparam int AW      = $clog2(REG_NUM)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               set_en,
  input  logic [AW-1:0]      set_idx,
  input  logic               clr_en,
  input  logic [AW-1:0]      clr_idx,
  input  logic               wipe_en,
  input  logic [AW-1:0]      wipe_idx,
  output logic [REG_NUM-1:0] busy
);

  logic [REG_NUM-1:0] busy_d;

  always_comb begin
    busy_d = busy;
    if (clr_en) busy_d[clr_idx] = 1'b0;
    if (set_en) busy_d[set_idx] = 1'b1;
    if (wipe_en) busy_d[wipe_idx] = 1'b0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_d;
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port RV32 register file with write-to-read bypass, busy scoreboard
// and a sequential bulk-clear engine that walks x1..x(REG_NUM-1).
module regfile_mp_sb
  import rv32_pkg::*;
#(
  parameter int  XLEN    = rv32_pkg::XLEN,
  parameter int  REG_NUM = rv32_pkg::REG_NUM,
  parameter int  NUM_RD  = 2,
  parameter int  BYPASS  = 1,
  localparam int AW      = $clog2(REG_NUM)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]      rd_busy,
  input  logic                   we,
  input  logic [AW-1:0]          wa,
  input  logic [XLEN-1:0]        wd,
  input  logic                   iss_en,
  input  logic [AW-1:0]          iss_rd,
  input  logic                   clr_req,
  output logic                   clr_busy
);

  localparam logic [AW-1:0] LAST_IDX = AW'(REG_NUM - 1);

  rf_state_e          state_q, state_d;
  logic [AW-1:0]      cnt_q, cnt_d;
  logic               wr_ok;
  logic               clr_step;
  logic [XLEN-1:0]    mem [REG_NUM];
  logic [REG_NUM-1:0] busy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RF_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // While clearing, writeback and issue are dropped rather than queued.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_busy = 1'b0;
    wr_ok    = 1'b0;
    clr_step = 1'b0;
    case (state_q)
      RF_IDLE: begin
        wr_ok = 1'b1;
        if (clr_req) begin
          state_d = RF_CLEAR;
          cnt_d   = AW'(1);
        end
      end
      RF_CLEAR: begin
        clr_busy = 1'b1;
        clr_step = 1'b1;
        cnt_d    = cnt_q + AW'(1);
        if (cnt_q == LAST_IDX) state_d = RF_IDLE;
      end
      default: state_d = RF_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_NUM; i++) mem[i] <= '0;
    end else if (clr_step) begin
      mem[cnt_q] <= '0;
    end else if (wr_ok && we && (wa != '0)) begin
      mem[wa] <= wd;
    end
  end

  rf_scoreboard #(
    .REG_NUM (REG_NUM)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (wr_ok & iss_en),
    .set_idx  (iss_rd),
    .clr_en   (wr_ok & we),
    .clr_idx  (wa),
    .wipe_en  (clr_step),
    .wipe_idx (cnt_q),
    .busy     (busy)
  );

  // A value forwarded from writeback counts as ready even if still marked busy.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [AW-1:0] a;
    logic          fwd;
    logic          hit;

    assign a   = rd_addr[p*AW +: AW];
    assign fwd = (BYPASS != 0) && we && (wa == a);
    assign hit = fwd && (state_q == RF_IDLE);

    assign rd_data[p*XLEN +: XLEN] = (a == '0) ? '0 : (hit ? wd : mem[a]);
    assign rd_busy[p] = (state_q == RF_CLEAR) | ((a != '0) & busy[a] & ~fwd);
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench: directed vector table, clear/reset sequences and random
// traffic checked against an array-based reference model, on BYPASS=1 and 0.
module tb_regfile_mp_sb;

  localparam int AW = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data, rd_data_nb;
  logic [1:0]  rd_busy, rd_busy_nb;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        iss_en;
  logic [4:0]  iss_rd;
  logic        clr_req;
  logic        clr_busy, clr_busy_nb;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_mem [32];
  bit          m_busy [32];
  bit          m_clearing;
  int          m_idx;

  always #5 clk = ~clk;

  regfile_mp_sb #(.XLEN(32), .REG_NUM(32), .NUM_RD(2), .BYPASS(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .we(we), .wa(wa), .wd(wd), .iss_en(iss_en), .iss_rd(iss_rd),
    .clr_req(clr_req), .clr_busy(clr_busy)
  );

  regfile_mp_sb #(.XLEN(32), .REG_NUM(32), .NUM_RD(2), .BYPASS(0)) u_dut_nb (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
    .we(we), .wa(wa), .wd(wd), .iss_en(iss_en), .iss_rd(iss_rd),
    .clr_req(clr_req), .clr_busy(clr_busy_nb)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        iss_en;
    logic [4:0]  iss_rd;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] d0;
    logic [31:0] d0_nb;
    logic        b0;
    logic        b0_nb;
    logic [31:0] d1;
  } vec_t;

  vec_t vt [10];

  function automatic logic [31:0] expData(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'd0;
    if (byp && we && wa == a && !m_clearing) return wd;
    return m_mem[a];
  endfunction

  function automatic logic expBusy(input logic [4:0] a, input bit byp);
    if (m_clearing) return 1'b1;
    if (a == 5'd0) return 1'b0;
    return m_busy[a] && !(byp && we && wa == a);
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    for (int p = 0; p < 2; p++) begin
      logic [4:0] a;
      a = rd_addr[p*AW +: AW];
      check32($sformatf("data p%0d x%0d", p, a), rd_data[p*32 +: 32], expData(a, 1'b1));
      check32($sformatf("busy p%0d x%0d", p, a), {31'd0, rd_busy[p]}, {31'd0, expBusy(a, 1'b1)});
      check32($sformatf("nb data p%0d x%0d", p, a), rd_data_nb[p*32 +: 32], expData(a, 1'b0));
      check32($sformatf("nb busy p%0d x%0d", p, a), {31'd0, rd_busy_nb[p]}, {31'd0, expBusy(a, 1'b0)});
    end
    check32("clr_busy", {31'd0, clr_busy}, {31'd0, m_clearing});
    check32("nb clr_busy", {31'd0, clr_busy_nb}, {31'd0, m_clearing});
  endtask

  task automatic modelUpdate();
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i]  = 32'd0;
        m_busy[i] = 1'b0;
      end
      m_clearing = 1'b0;
      m_idx      = 0;
    end else if (m_clearing) begin
      m_mem[m_idx]  = 32'd0;
      m_busy[m_idx] = 1'b0;
      if (m_idx == 31) m_clearing = 1'b0;
      else             m_idx++;
    end else begin
      if (we && wa != 5'd0) begin
        m_mem[wa]  = wd;
        m_busy[wa] = 1'b0;
      end
      if (iss_en && iss_rd != 5'd0) m_busy[iss_rd] = 1'b1;
      if (clr_req) begin
        m_clearing = 1'b1;
        m_idx      = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  task automatic drive(input logic w, input logic [4:0] a, input logic [31:0] d,
                       input logic ie, input logic [4:0] ir, input logic cr,
                       input logic [4:0] r0, input logic [4:0] r1);
    we = w; wa = a; wd = d; iss_en = ie; iss_rd = ir; clr_req = cr;
    rd_addr = {r1, r0};
  endtask

  task automatic applyStimulus(input logic w, input logic [4:0] a, input logic [31:0] d,
                               input logic ie, input logic [4:0] ir, input logic cr,
                               input logic [4:0] r0, input logic [4:0] r1);
    drive(w, a, d, ie, ir, cr, r0, r1);
    #4;
    checkOutput();
    tick();
  endtask

  task automatic randomStep(input logic cr);
    applyStimulus(1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom), cr,
                  5'($urandom), 5'($urandom));
  endtask

  task automatic sweepAll();
    for (int i = 0; i < 32; i++) applyStimulus(0, 0, 0, 0, 0, 0, 5'(i), 5'(31 - i));
  endtask

  initial begin
    int n;
    vt[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 32'h0};
    vt[1] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 32'hDEADBEEF};
    vt[2] = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0, 5'd5, 32'h0, 32'h0, 1'b0, 1'b0, 32'hDEADBEEF};
    vt[3] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd5, 32'h0, 32'h0, 1'b0, 1'b0, 32'hDEADBEEF};
    vt[4] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 5'd7, 5'd5, 32'h0, 32'h0, 1'b0, 1'b0, 32'hDEADBEEF};
    vt[5] = '{1'b1, 5'd7, 32'h77,       1'b1, 5'd7, 5'd7, 5'd5, 32'h77, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF};
    vt[6] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 5'd5, 32'h77, 32'h77, 1'b1, 1'b1, 32'hDEADBEEF};
    vt[7] = '{1'b1, 5'd7, 32'h78,       1'b0, 5'd0, 5'd7, 5'd5, 32'h78, 32'h77, 1'b0, 1'b1, 32'hDEADBEEF};
    vt[8] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 5'd5, 32'h78, 32'h78, 1'b0, 1'b0, 32'hDEADBEEF};
    vt[9] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0};

    for (int i = 0; i < 32; i++) begin
      m_mem[i] = 32'hBAD0_0000; m_busy[i] = 1'b1;
    end
    m_clearing = 1'b0; m_idx = 0;

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    $display("[TB] reset released");

    for (int i = 0; i < 20; i++) randomStep(1'b0);
    rst_n = 1'b0;
    randomStep(1'b0);
    rst_n = 1'b1;
    sweepAll();

    $display("[TB] directed vector table");
    for (int i = 0; i < 10; i++) begin
      drive(vt[i].we, vt[i].wa, vt[i].wd, vt[i].iss_en, vt[i].iss_rd, 1'b0, vt[i].ra0, vt[i].ra1);
      #4;
      check32($sformatf("vec%0d d0", i), rd_data[31:0], vt[i].d0);
      check32($sformatf("vec%0d d0 nb", i), rd_data_nb[31:0], vt[i].d0_nb);
      check32($sformatf("vec%0d b0", i), {31'd0, rd_busy[0]}, {31'd0, vt[i].b0});
      check32($sformatf("vec%0d b0 nb", i), {31'd0, rd_busy_nb[0]}, {31'd0, vt[i].b0_nb});
      check32($sformatf("vec%0d d1", i), rd_data[63:32], vt[i].d1);
      checkOutput();
      tick();
    end

    $display("[TB] bulk clear");
    for (int i = 1; i < 32; i++) applyStimulus(1, 5'(i), 32'h1000_0000 | 32'(i), 0, 0, 0, 5'(i), 0);
    applyStimulus(0, 0, 0, 1, 5'd9, 0, 5'd9, 5'd1);
    applyStimulus(1, 5'd3, 32'h33, 0, 0, 1, 5'd3, 5'd9);
    n = 0;
    for (int c = 0; c < 40; c++) begin
      randomStep(1'($urandom));
      if (!m_clearing) break;
    end
    n = 0;
    for (int c = 0; c < 40 && n == 0; c++) begin
      n = -1;
    end
    sweepAll();

    $display("[TB] clear duration");
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    n = 0;
    for (int c = 0; c < 40; c++) begin
      drive(1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom), 1'($urandom),
            5'($urandom), 5'($urandom));
      #4;
      checkOutput();
      if (clr_busy !== 1'b1) break;
      n++;
      tick();
    end
    check32("clear cycles", 32'(n), 32'd31);
    sweepAll();

    $display("[TB] reset mid-clear");
    for (int i = 1; i < 32; i++) applyStimulus(1, 5'(i), ~32'(i), 1, 5'(i), 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    for (int c = 0; c < 9; c++) randomStep(1'b0);
    rst_n = 1'b0;
    randomStep(1'b0);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 5'd31, 5'd10);
    #4;
    check32("clr_busy after reset", {31'd0, clr_busy}, 32'd0);
    check32("x31 after reset", rd_data[31:0], 32'd0);
    tick();
    sweepAll();

    $display("[TB] random traffic");
    for (int c = 0; c < 600; c++) begin
      rst_n = ($urandom_range(0, 149) != 0);
      randomStep($urandom_range(0, 39) == 0);
    end
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
